// File: rtl/pipe_cla_adder_if.sv
// Operand/result handshake bundle for pipe_cla_adder.
// ADDER_SUB_EN adds in_sub (toward the adder) and ovf (from the adder).
interface pipe_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_SUB_EN
  logic             in_sub;
  logic             ovf;

  modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipe_cla_adder.sv
// Pipelined CLA adder: one BLOCK-bit lookahead slice per stage; ADDER_SUB_EN adds A-B and ovf.
// Latency NBLK cycles from accept to out_valid, one result per cycle.
// A held output (out_valid & ~out_ready) freezes every stage and drops in_ready combinationally.
module pipe_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic             clk,
  input logic             rst,
  pipe_cla_adder_if.slave bus
);
  localparam int NBLK = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_param
    $error("pipe_cla_adder: WIDTH %0d must be a non-zero multiple of BLOCK %0d", WIDTH, BLOCK);
  end

  typedef struct packed {
    logic             vld;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  // Carries of one slice as a flat sum of products of g/p terms (no ripple).
  function automatic logic [BLOCK:0] cla_carry(input logic [BLOCK-1:0] g,
                                               input logic [BLOCK-1:0] p,
                                               input logic             c0);
    logic [BLOCK:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  stg_t head;
  stg_t st     [NBLK];
  stg_t st_nxt [NBLK];
  logic stall;

`ifdef ADDER_SUB_EN
  logic ovf_nxt;
  logic ovf_q;
`endif

  always_comb begin
    head     = '0;
    head.vld = bus.in_valid;
    head.a   = bus.in_a;
`ifdef ADDER_SUB_EN
    head.b   = bus.in_sub ? ~bus.in_b : bus.in_b;
    head.c   = bus.in_sub | bus.in_cin;
`else
    head.b   = bus.in_b;
    head.c   = bus.in_cin;
`endif
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    stg_t           cur;
    stg_t           nxt;
    logic [BLOCK-1:0] ga;
    logic [BLOCK-1:0] gb;
    logic [BLOCK:0]   c;

    if (k == 0) begin : g_head
      assign cur = head;
    end else begin : g_body
      assign cur = st[k-1];
    end

    assign ga = cur.a[k*BLOCK +: BLOCK];
    assign gb = cur.b[k*BLOCK +: BLOCK];
    assign c  = cla_carry(ga & gb, ga ^ gb, cur.c);

    always_comb begin
      nxt                     = cur;
      nxt.s[k*BLOCK +: BLOCK] = ga ^ gb ^ c[BLOCK-1:0];
      nxt.c                   = c[BLOCK];
    end
    assign st_nxt[k] = nxt;

`ifdef ADDER_SUB_EN
    // Signed overflow: carry into the MSB disagrees with the carry out of it.
    if (k == NBLK - 1) begin : g_last
      assign ovf_nxt = c[BLOCK-1] ^ c[BLOCK];
    end
`endif
  end

  assign stall        = st[NBLK-1].vld & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) st[k] <= '0;
`ifdef ADDER_SUB_EN
      ovf_q <= 1'b0;
`endif
    end else if (!stall) begin
      for (int k = 0; k < NBLK; k++) st[k] <= st_nxt[k];
`ifdef ADDER_SUB_EN
      ovf_q <= ovf_nxt;
`endif
    end
  end

  assign bus.out_valid = st[NBLK-1].vld;
  assign bus.sum       = st[NBLK-1].s;
  assign bus.cout      = st[NBLK-1].c;
`ifdef ADDER_SUB_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=16, BLOCK=4); ADDER_SUB_EN enables subtract vectors.
module tb_pipe_cla_adder;
  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NBLK  = WIDTH / BLOCK;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_cla_adder_if #(.WIDTH(WIDTH)) bus ();
  pipe_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic             vld;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_acc  = 0;
  int   n_out  = 0;
  res_t mdl [NBLK];   // expected contents of each pipeline slot, slot NBLK-1 is the output

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Exact arithmetic reference: plain integer add/subtract, signed range test for ovf.
  function automatic res_t ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic sub);
    res_t r;
    int   sa, sb, sr;
    sa    = int'($signed(a));
    sb    = int'($signed(b));
    r.vld = 1'b1;
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      {r.cout, r.sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      sr              = sa + sb + int'(cin);
    end
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NBLK; k++) mdl[k] = '{default: '0};
  endtask

  // One clock: drive, check outputs against the slot model, advance model, step past the edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input logic ordy);
    logic stall;
    logic sub_eff;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.out_ready = ordy;
`ifdef ADDER_SUB_EN
    bus.in_sub    = sub;
    sub_eff       = sub;
`else
    sub_eff       = 1'b0;
`endif
    #2;
    stall = mdl[NBLK-1].vld && !ordy;
    chk("in_ready", bus.in_ready, !stall);
    chk("out_valid", bus.out_valid, mdl[NBLK-1].vld);
    if (mdl[NBLK-1].vld) begin
      chk("sum", bus.sum, mdl[NBLK-1].sum);
      chk("cout", bus.cout, mdl[NBLK-1].cout);
`ifdef ADDER_SUB_EN
      chk("ovf", bus.ovf, mdl[NBLK-1].ovf);
`endif
      if (ordy) n_out++;
    end
    if (!stall) begin
      for (int k = NBLK - 1; k > 0; k--) mdl[k] = mdl[k-1];
      if (v) begin
        mdl[0] = ref_op(a, b, cin, sub_eff);
        n_acc++;
      end else begin
        mdl[0] = '{default: '0};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  task automatic rand_op(input logic ordy);
    cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_sum", bus.sum, 16'h0000);
    chk("reset_cout", bus.cout, 1'b0);
`ifdef ADDER_SUB_EN
    chk("reset_ovf", bus.ovf, 1'b0);
`endif
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    vec_t vecs[$];
    int   out0;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
`ifdef ADDER_SUB_EN
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0});
`endif

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    clear_model();
    do_reset();

    // Directed vectors: result must appear exactly NBLK edges after the accepting edge.
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1);
      for (int d = 1; d < NBLK; d++) idle(1'b1);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("tbl%0d_sum", i), bus.sum, vecs[i].sum);
      chk($sformatf("tbl%0d_cout", i), bus.cout, vecs[i].cout);
`ifdef ADDER_SUB_EN
      chk($sformatf("tbl%0d_ovf", i), bus.ovf, vecs[i].ovf);
`endif
    end
    idle(1'b1);

    // Back-to-back stream of 20 pairs: results on consecutive cycles, in order.
    out0 = n_out;
    for (int i = 0; i < 20; i++) rand_op(1'b1);
    for (int i = 0; i < NBLK; i++) idle(1'b1);
    chk("stream_count", n_out - out0, 20);

    // Fill the pipe, hold the output for 5 cycles with input still offered, then release.
    for (int i = 0; i < NBLK; i++) rand_op(1'b1);
    for (int i = 0; i < 5; i++) rand_op(1'b0);
    rand_op(1'b1);
    rand_op(1'b1);
    for (int i = 0; i < NBLK + 1; i++) idle(1'b1);
    chk("bp_drain_count", n_out, n_acc);

    // Random valid/ready mix.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) rand_op(1'($urandom_range(0, 2) != 0));
      else idle(1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < NBLK + 2; i++) idle(1'b1);
    chk("random_drain_count", n_out, n_acc);

    // Reset with three items in flight: nothing stale may emerge afterwards.
    for (int i = 0; i < 3; i++) rand_op(1'b1);
    do_reset();
    for (int i = 0; i < NBLK + 2; i++) idle(1'b1);
    cycle(1'b1, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 1'b1);
    for (int d = 1; d < NBLK; d++) idle(1'b1);
    chk("post_reset_valid", bus.out_valid, 1'b1);
    chk("post_reset_sum", bus.sum, 16'h0000);
    chk("post_reset_cout", bus.cout, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
